// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU operation codes, ALUOp selector and the
// entry held in the issue skid buffer.
package alu_pkg;
  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 4;
  localparam int ALU_RD_W   = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_EQ   = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL_MEM   = 2'b00,
    SEL_BR    = 2'b01,
    SEL_ARITH = 2'b10,
    SEL_PASS  = 2'b11
  } alu_sel_e;

  typedef struct packed {
    alu_op_e               op;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_RD_W-1:0]   rd;
    logic                  br;
    logic                  inv;
    logic                  ill;
  } issue_entry_t;

  // Shifters only look at the low five bits of the shift amount.
  function automatic logic is_shift(alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction
endpackage

// File: rtl/alu_issue_if.sv
// Decode-side and execute-side handshake bundle of the ALU issue stage.
interface alu_issue_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
);
  logic                     Flush;
  logic                     InValid;
  logic                     InReady;
  logic [1:0]               ALUOp;
  logic [2:0]               Funct3;
  logic                     Funct7b5;
  logic                     IsRType;
  logic [DATA_WIDTH-1:0]    InSrcA;
  logic [DATA_WIDTH-1:0]    InSrcB;
  logic [REG_ADDR_W-1:0]    InRd;
  logic                     OutValid;
  logic                     OutReady;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [REG_ADDR_W-1:0]    OutRd;
  logic                     IsBranch;
  logic                     BrInvert;
  logic                     Illegal;

  modport slave (
    input  Flush, InValid, ALUOp, Funct3, Funct7b5, IsRType, InSrcA, InSrcB, InRd, OutReady,
    output InReady, OutValid, Operation, SrcA, SrcB, OutRd, IsBranch, BrInvert, Illegal
  );
  modport master (
    output Flush, InValid, ALUOp, Funct3, Funct7b5, IsRType, InSrcA, InSrcB, InRd, OutReady,
    input  InReady, OutValid, Operation, SrcA, SrcB, OutRd, IsBranch, BrInvert, Illegal
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational ALUOp/funct3/funct7b5 decode into ALU operation and branch flags.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       is_rtype_i,
  output alu_op_e    op_o,
  output logic       br_o,
  output logic       inv_o,
  output logic       ill_o
);
  always_comb begin
    op_o  = ALU_ADD;
    br_o  = 1'b0;
    inv_o = 1'b0;
    ill_o = 1'b0;
    case (alu_sel_e'(alu_op_i))
      SEL_BR: begin
        br_o = 1'b1;
        // funct3[0] selects the inverted sense: BNE/BGE/BGEU
        case (funct3_i)
          3'b000:  op_o = ALU_EQ;
          3'b001: begin op_o = ALU_EQ;   inv_o = 1'b1; end
          3'b100:  op_o = ALU_SLT;
          3'b101: begin op_o = ALU_SLT;  inv_o = 1'b1; end
          3'b110:  op_o = ALU_SLTU;
          3'b111: begin op_o = ALU_SLTU; inv_o = 1'b1; end
          default: ill_o = 1'b1;
        endcase
      end
      SEL_ARITH: begin
        case (funct3_i)
          3'b000:  op_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  op_o = ALU_SLL;
          3'b010:  op_o = ALU_SLT;
          3'b011:  op_o = ALU_SLTU;
          3'b100:  op_o = ALU_XOR;
          3'b101:  op_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  op_o = ALU_OR;
          default: op_o = ALU_AND;
        endcase
      end
      default: op_o = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: decodes the ALU operation and registers it with its operands
// through a two-entry skid buffer so InReady never depends combinationally on OutReady.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = ALU_DATA_W,
  parameter int OPCODE_LENGTH = ALU_OP_W,
  parameter int REG_ADDR_W    = ALU_RD_W
) (
  input  logic       clk,
  input  logic       reset,
  alu_issue_if.slave bus
);
  alu_op_e      dec_op;
  logic         dec_br, dec_inv, dec_ill;
  issue_entry_t in_entry;
  issue_entry_t main_q, main_d, skid_q, skid_d;
  logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic         in_ready_q;
  logic         accept, issue;

  alu_decode u_decode (
    .alu_op_i   (bus.ALUOp),
    .funct3_i   (bus.Funct3),
    .funct7b5_i (bus.Funct7b5),
    .is_rtype_i (bus.IsRType),
    .op_o       (dec_op),
    .br_o       (dec_br),
    .inv_o      (dec_inv),
    .ill_o      (dec_ill)
  );

  always_comb begin
    in_entry     = '0;
    in_entry.op  = dec_op;
    in_entry.a   = bus.InSrcA;
    in_entry.b   = is_shift(dec_op) ? {{(ALU_DATA_W-5){1'b0}}, bus.InSrcB[4:0]} : bus.InSrcB;
    in_entry.rd  = bus.InRd;
    in_entry.br  = dec_br;
    in_entry.inv = dec_inv;
    in_entry.ill = dec_ill;
  end

  assign accept = bus.InValid & in_ready_q;
  assign issue  = main_vld_q & bus.OutReady;

  // Skid only fills while main is stalled; it always drains into main before new input.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (bus.Flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q) begin
      if (accept) begin
        main_d     = in_entry;
        main_vld_d = 1'b1;
      end
    end else if (issue) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d = in_entry;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_entry;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= !skid_vld_d;
    end
  end

  assign bus.InReady   = in_ready_q;
  assign bus.OutValid  = main_vld_q;
  assign bus.Operation = main_q.op;
  assign bus.SrcA      = main_q.a;
  assign bus.SrcB      = main_q.b;
  assign bus.OutRd     = main_q.rd;
  assign bus.IsBranch  = main_q.br;
  assign bus.BrInvert  = main_q.inv;
  assign bus.Illegal   = main_q.ill;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode table, shift masking, skid backpressure, flush, async reset.
module tb_alu_issue;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_issue_if bus ();

  alu_issue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                      input logic isr, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    bus.InValid  = 1'b1;
    bus.ALUOp    = aluop;
    bus.Funct3   = f3;
    bus.Funct7b5 = f7;
    bus.IsRType  = isr;
    bus.InSrcA   = a;
    bus.InSrcB   = b;
    bus.InRd     = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    bus.Flush    = 1'b0;
    bus.InValid  = 1'b0;
    bus.ALUOp    = 2'b00;
    bus.Funct3   = 3'b000;
    bus.Funct7b5 = 1'b0;
    bus.IsRType  = 1'b0;
    bus.InSrcA   = '0;
    bus.InSrcB   = '0;
    bus.InRd     = '0;
    bus.OutReady = 1'b1;
    #2;
    chk("rst_inready",  bus.InReady, 0);
    chk("rst_outvalid", bus.OutValid, 0);
    chk("rst_op",       bus.Operation, 0);
    chk("rst_srca",     bus.SrcA, 0);
    chk("rst_flags",    {bus.IsBranch, bus.BrInvert, bus.Illegal}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_rst_inready", bus.InReady, 1);

    // R-type SUB
    push(2'b10, 3'b000, 1'b1, 1'b1, 32'd7, 32'd3, 5'd1);
    step();
    chk("sub_valid", bus.OutValid, 1);
    chk("sub_op",    bus.Operation, 4'b0001);
    chk("sub_a",     bus.SrcA, 7);
    chk("sub_b",     bus.SrcB, 3);
    chk("sub_rd",    bus.OutRd, 1);

    // SRA masks shift amount
    push(2'b10, 3'b101, 1'b1, 1'b1, 32'd9, 32'hFFFF_FFE4, 5'd2);
    step();
    chk("sra_op", bus.Operation, 4'b0111);
    chk("sra_b",  bus.SrcB, 32'h0000_0004);

    // I-type with bit30 set stays ADD
    push(2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'hFFFF_FFE4, 5'd3);
    step();
    chk("addi_op", bus.Operation, 4'b0000);
    chk("addi_b",  bus.SrcB, 32'hFFFF_FFE4);

    // BGE: SLT inverted
    push(2'b01, 3'b101, 1'b0, 1'b0, 32'd1, 32'd2, 5'd0);
    step();
    chk("bge_op",    bus.Operation, 4'b1000);
    chk("bge_flags", {bus.IsBranch, bus.BrInvert, bus.Illegal}, 3'b110);

    // Undefined branch funct3
    push(2'b01, 3'b011, 1'b0, 1'b0, 32'd1, 32'd2, 5'd0);
    step();
    chk("bill_op",    bus.Operation, 4'b0000);
    chk("bill_flags", {bus.IsBranch, bus.BrInvert, bus.Illegal}, 3'b101);

    // LUI pass-add with shift-like funct3 keeps B unmasked
    push(2'b11, 3'b101, 1'b1, 1'b0, 32'd0, 32'h1234_5000, 5'd4);
    step();
    chk("lui_op", bus.Operation, 4'b0000);
    chk("lui_b",  bus.SrcB, 32'h1234_5000);

    bus.InValid = 1'b0;
    step();
    chk("drain_valid", bus.OutValid, 0);

    // Backpressure: three pushes, only two taken
    bus.OutReady = 1'b0;
    push(2'b10, 3'b110, 1'b0, 1'b1, 32'h11, 32'd0, 5'd11);
    step();
    chk("bp1_valid", bus.OutValid, 1);
    chk("bp1_ready", bus.InReady, 1);
    chk("bp1_a",     bus.SrcA, 32'h11);
    chk("bp1_op",    bus.Operation, 4'b0011);
    push(2'b10, 3'b111, 1'b0, 1'b1, 32'h22, 32'd0, 5'd12);
    step();
    chk("bp2_ready", bus.InReady, 0);
    chk("bp2_a",     bus.SrcA, 32'h11);
    push(2'b10, 3'b100, 1'b0, 1'b1, 32'h33, 32'd0, 5'd13);
    step();
    chk("bp3_ready", bus.InReady, 0);
    chk("bp3_a",     bus.SrcA, 32'h11);
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    step();
    chk("bp4_valid", bus.OutValid, 1);
    chk("bp4_a",     bus.SrcA, 32'h22);
    chk("bp4_op",    bus.Operation, 4'b0100);
    chk("bp4_rd",    bus.OutRd, 12);
    chk("bp4_ready", bus.InReady, 1);
    step();
    chk("bp5_valid", bus.OutValid, 0);

    // Flush with both entries held and a same-cycle input
    bus.OutReady = 1'b0;
    push(2'b00, 3'b000, 1'b0, 1'b0, 32'hA1, 32'd0, 5'd21);
    step();
    push(2'b00, 3'b000, 1'b0, 1'b0, 32'hA2, 32'd0, 5'd22);
    step();
    chk("fl_pre_ready", bus.InReady, 0);
    bus.Flush = 1'b1;
    push(2'b00, 3'b000, 1'b0, 1'b0, 32'h99, 32'd0, 5'd23);
    step();
    chk("fl_valid", bus.OutValid, 0);
    chk("fl_ready", bus.InReady, 1);
    bus.Flush    = 1'b0;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    step();
    chk("fl_still_empty", bus.OutValid, 0);
    push(2'b00, 3'b000, 1'b0, 1'b0, 32'h55, 32'd0, 5'd24);
    step();
    chk("fl_new_valid", bus.OutValid, 1);
    chk("fl_new_a",     bus.SrcA, 32'h55);
    bus.InValid = 1'b0;
    step();
    chk("fl_new_drain", bus.OutValid, 0);

    // Async reset with entries held
    bus.OutReady = 1'b0;
    push(2'b10, 3'b100, 1'b0, 1'b1, 32'h66, 32'd1, 5'd25);
    step();
    chk("ar_op_pre", bus.Operation, 4'b0010);
    push(2'b10, 3'b100, 1'b0, 1'b1, 32'h67, 32'd1, 5'd26);
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", bus.OutValid, 0);
    chk("ar_op",    bus.Operation, 0);
    chk("ar_a",     bus.SrcA, 0);
    chk("ar_ready", bus.InReady, 0);
    bus.InValid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("ar_post_ready", bus.InReady, 1);
    chk("ar_post_valid", bus.OutValid, 0);
    bus.OutReady = 1'b1;
    push(2'b00, 3'b000, 1'b0, 1'b0, 32'h77, 32'd0, 5'd27);
    step();
    chk("ar_resume_valid", bus.OutValid, 1);
    chk("ar_resume_a",     bus.SrcA, 32'h77);
    bus.InValid = 1'b0;
    step();
    chk("ar_resume_drain", bus.OutValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
